timer_tick_scheduler: RTL

//  Avalon-MM master that sequences the 16-bit-register interval timer slave: programs period,

---
 rtl/timer_tick_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/timer_tick_scheduler.sv
// timer_tick_scheduler: Avalon-MM master that programs, starts/stops and services an interval timer slave
//   and derives NUM_CH divided tick pulses from its serviced timeouts.
// Optional feature macro: TIMER_SCHED_SNAP_EN (adds snapshot read of the slave counter).
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cfg_start/cfg_stop      1-cycle pulses: program cfg_period and start / stop the timer
//   cfg_period              32-bit timer period
//   ch_div                  per-channel divisor, channel i = [i*DIV_W +: DIV_W], 0 disables
//   busy, running           sequencing in progress / timer started and not stopped
//   tick_count, ch_pulse    serviced timeouts (wraps) / 1-cycle divided tick pulses
//   tmr_*                   registered Avalon-MM master towards the timer slave, tmr_irq level input
//   snap_req/snap_valid/snap_value  (TIMER_SCHED_SNAP_EN) snapshot request and 32-bit result
module timer_tick_scheduler #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8,
  parameter int TICK_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic [31:0]             cfg_period,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic                    busy,
  output logic                    running,
  output logic [TICK_W-1:0]       tick_count,
  output logic [NUM_CH-1:0]       ch_pulse,
  output logic [2:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic [15:0]             tmr_readdata,
  input  logic                    tmr_irq
`ifdef TIMER_SCHED_SNAP_EN
  ,
  input  logic                    snap_req,
  output logic                    snap_valid,
  output logic [31:0]             snap_value
`endif
);
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, WR_STOP, CLR, WAIT
`ifdef TIMER_SCHED_SNAP_EN
    , SNAP_WR, SNAP_AL, SNAP_AH, SNAP_CAP
`endif
  } state_t;
  state_t state, nxt;
  logic [15:0] per_hi;
  logic from_run;
  logic tick;
  logic [2:0] a_n;
  logic [15:0] d_n;
  logic cs_n;
  logic [NUM_CH-1:0][DIV_W-1:0] div, cnt, cnt_n;
  logic [NUM_CH-1:0] pul_n;
  assign div  = ch_div;
  assign busy = !(state == IDLE || state == RUN);
  assign tick = state == RUN && nxt == CLR;
`ifdef TIMER_SCHED_SNAP_EN
  logic snap_pend;
  logic [15:0] snap_lo;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cfg_start ? WR_PL : tmr_irq ? CLR : IDLE;
      WR_PL:   nxt = WR_PH;
      WR_PH:   nxt = WR_CTRL;
      WR_CTRL: nxt = RUN;
`ifdef TIMER_SCHED_SNAP_EN
      RUN:     nxt = cfg_stop ? WR_STOP : cfg_start ? WR_PL : tmr_irq ? CLR : (snap_req || snap_pend) ? SNAP_WR : RUN;
      SNAP_WR: nxt = SNAP_AL;
      SNAP_AL: nxt = SNAP_AH;
      SNAP_AH: nxt = SNAP_CAP;
      SNAP_CAP: nxt = RUN;
`else
      RUN:     nxt = cfg_stop ? WR_STOP : cfg_start ? WR_PL : tmr_irq ? CLR : RUN;
`endif
      WR_STOP: nxt = IDLE;
      CLR:     nxt = WAIT;
      WAIT:    nxt = from_run ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Bus outputs are decoded from the next state and registered, so each write appears in its own state cycle.
  always_comb begin
    a_n  = 3'd0;
    d_n  = 16'd0;
    cs_n = 1'b0;
    case (nxt)
      WR_PL:   begin a_n = 3'd2; d_n = cfg_period[15:0]; cs_n = 1'b1; end
      WR_PH:   begin a_n = 3'd3; d_n = per_hi; cs_n = 1'b1; end
      WR_CTRL: begin a_n = 3'd1; d_n = 16'h0007; cs_n = 1'b1; end
      WR_STOP: begin a_n = 3'd1; d_n = 16'h0008; cs_n = 1'b1; end
      CLR:     cs_n = 1'b1;
`ifdef TIMER_SCHED_SNAP_EN
      SNAP_WR: begin a_n = 3'd4; cs_n = 1'b1; end
      SNAP_AL: a_n = 3'd4;
      SNAP_AH: a_n = 3'd5;
`endif
      default: ;
    endcase
  end
  // A counter at or beyond div-1 (e.g. after the divisor shrank) pulses and restarts.
  always_comb begin
    cnt_n = cnt;
    pul_n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (div[i] == '0) cnt_n[i] = '0;
      else if (tick) begin
        pul_n[i] = cnt[i] >= div[i] - 1'b1;
        cnt_n[i] = pul_n[i] ? '0 : cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      tmr_address    <= 3'd0;
      tmr_writedata  <= 16'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      per_hi         <= 16'd0;
      from_run       <= 1'b0;
      running        <= 1'b0;
      tick_count     <= '0;
      cnt            <= '0;
      ch_pulse       <= '0;
    end else begin
      state          <= nxt;
      tmr_address    <= a_n;
      tmr_writedata  <= d_n;
      tmr_chipselect <= cs_n;
      tmr_write_n    <= !cs_n;
      per_hi         <= nxt == WR_PL ? cfg_period[31:16] : per_hi;
      from_run       <= nxt == CLR ? state == RUN : from_run;
      running        <= nxt == WR_STOP ? 1'b0 : state == WR_CTRL ? 1'b1 : running;
      tick_count     <= tick ? tick_count + 1'b1 : tick_count;
      cnt            <= cnt_n;
      ch_pulse       <= pul_n;
    end
  end
`ifdef TIMER_SCHED_SNAP_EN
  // Readdata lags the address by one cycle: low half arrives in SNAP_AH, high half in SNAP_CAP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_pend  <= 1'b0;
      snap_lo    <= 16'd0;
      snap_valid <= 1'b0;
      snap_value <= 32'd0;
    end else begin
      snap_pend  <= state != IDLE && (snap_pend || snap_req) && nxt != SNAP_WR;
      snap_lo    <= state == SNAP_AH ? tmr_readdata : snap_lo;
      snap_valid <= state == SNAP_CAP;
      snap_value <= state == SNAP_CAP ? {tmr_readdata, snap_lo} : snap_value;
    end
  end
`endif
endmodule
